// File: rtl/filter_mon_pkg.sv
// Shared types and helpers for the filter settle monitor.
package filter_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Fill bit replicated across settle_cycles to flag a timeout.
   localparam logic CNT_ALL_ONES = 1'b1;

   // Width of a run-length counter that must reach 'hold'.
   function automatic int unsigned run_w(input int unsigned hold);
      return $clog2(hold + 1);
   endfunction

endpackage

// File: rtl/filter_settle_monitor_band_cmp.sv
// Signed band comparator: |v_mon - target| <= tol, and v_mon above target + tol.
module band_cmp #(
   parameter int unsigned WIDTH = 25
) (
   input  logic [WIDTH-1:0] v_mon,
   input  logic [WIDTH-1:0] target,
   input  logic [WIDTH-1:0] tol,
   output logic             in_band,
   output logic             above_band
);

   localparam int unsigned EW = WIDTH + 1;

   logic [EW-1:0]          err;
   logic [EW-1:0]          err_abs;
   logic signed [WIDTH+1:0] v_ext;
   logic signed [WIDTH+1:0] upper;

   // One extra bit keeps the difference exact; two extra bits keep target + tol exact.
   always_comb begin
      err        = {v_mon[WIDTH-1], v_mon} - {target[WIDTH-1], target};
      err_abs    = err[EW-1] ? EW'(~err + EW'(1)) : err;
      in_band    = (err_abs <= {1'b0, tol});
      v_ext      = {{2{v_mon[WIDTH-1]}}, v_mon};
      upper      = {{2{target[WIDTH-1]}}, target} + {2'b00, tol};
      above_band = (v_ext > upper);
   end

endmodule

// File: rtl/filter_settle_monitor.sv
// Step-response monitor: settle time, signed peak and overshoot of the filter output.
module filter_settle_monitor
   import filter_mon_pkg::*;
#(
   parameter int unsigned WIDTH       = 25,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned TIMEOUT     = 1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] v_mon,
   input  logic [WIDTH-1:0] target,
   input  logic [WIDTH-1:0] tol,
   output logic             busy,
   output logic             done,
   output logic             settled_ok,
   output logic             timed_out,
   output logic [CNT_W-1:0] settle_cycles,
   output logic [WIDTH-1:0] peak,
   output logic             overshoot
);

   localparam int unsigned      RUN_W     = run_w(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(TIMEOUT - 1);
   localparam logic [RUN_W-1:0] HOLD_LAST = RUN_W'(HOLD_CYCLES - 1);
   localparam logic [RUN_W-1:0] HOLD_MAX  = RUN_W'(HOLD_CYCLES);
   localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   target_q, target_d;
   logic [WIDTH-1:0]   tol_q, tol_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic [CNT_W-1:0]   sidx_q, sidx_d;
   logic               above_q, above_d;
   logic               busy_d, done_d, ok_d, to_d, ov_d;
   logic [CNT_W-1:0]   sc_d;
   logic [WIDTH-1:0]   peak_d;
   logic               in_band_c, above_c, settle_c;
   logic [CNT_W-1:0]   idx_c;

   // Band test of the live sample against the captured target/tol.
   band_cmp #(.WIDTH(WIDTH)) u_band (
      .v_mon      (v_mon),
      .target     (target_q),
      .tol        (tol_q),
      .in_band    (in_band_c),
      .above_band (above_c)
   );

   // Next-state and next-output logic; a sample above the band anywhere means peak exceeded it.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      tol_d    = tol_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      sidx_d   = sidx_q;
      above_d  = above_q;
      busy_d   = busy;
      done_d   = 1'b0;
      ok_d     = settled_ok;
      to_d     = timed_out;
      sc_d     = settle_cycles;
      peak_d   = peak;
      ov_d     = overshoot;
      settle_c = in_band_c && (run_q == HOLD_LAST);
      idx_c    = (run_q == '0) ? cnt_q : sidx_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = TRACK;
               target_d = target;
               tol_d    = tol;
               cnt_d    = '0;
               run_d    = '0;
               sidx_d   = '0;
               above_d  = 1'b0;
               busy_d   = 1'b1;
               ok_d     = 1'b0;
               to_d     = 1'b0;
               sc_d     = '0;
               peak_d   = MOST_NEG;
               ov_d     = 1'b0;
            end
         end
         TRACK: begin
            peak_d  = ($signed(v_mon) > $signed(peak)) ? v_mon : peak;
            above_d = above_q | above_c;
            if (in_band_c) begin
               run_d  = (run_q == HOLD_MAX) ? run_q : run_q + RUN_W'(1);
               sidx_d = idx_c;
            end else begin
               run_d = '0;
            end
            if (settle_c) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ok_d    = 1'b1;
               sc_d    = idx_c;
               ov_d    = above_q | above_c;
            end else if (cnt_q == LAST_IDX) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               to_d    = 1'b1;
               sc_d    = {CNT_W{CNT_ALL_ONES}};
               ov_d    = above_q | above_c;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, working and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         target_q      <= '0;
         tol_q         <= '0;
         cnt_q         <= '0;
         run_q         <= '0;
         sidx_q        <= '0;
         above_q       <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         settled_ok    <= 1'b0;
         timed_out     <= 1'b0;
         settle_cycles <= '0;
         peak          <= '0;
         overshoot     <= 1'b0;
      end else begin
         state_q       <= state_d;
         target_q      <= target_d;
         tol_q         <= tol_d;
         cnt_q         <= cnt_d;
         run_q         <= run_d;
         sidx_q        <= sidx_d;
         above_q       <= above_d;
         busy          <= busy_d;
         done          <= done_d;
         settled_ok    <= ok_d;
         timed_out     <= to_d;
         settle_cycles <= sc_d;
         peak          <= peak_d;
         overshoot     <= ov_d;
      end
   end

endmodule

// File: tb/tb_filter_settle_monitor.sv
// Scoreboard bench for filter_settle_monitor with directed step profiles.
module tb_filter_settle_monitor;

   localparam int unsigned W    = 25;
   localparam int unsigned CW   = 32;
   localparam int unsigned HOLD = 16;
   localparam int unsigned TMO  = 100;
   localparam logic [W-1:0] NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] POS = {1'b0, {(W-1){1'b1}}};

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  v_mon = '0;
   logic [W-1:0]  target = '0;
   logic [W-1:0]  tol = '0;
   logic          busy, done, settled_ok, timed_out, overshoot;
   logic [CW-1:0] settle_cycles;
   logic [W-1:0]  peak;

   typedef struct {
      int unsigned   done_cyc;
      logic          ok;
      logic          to;
      logic [CW-1:0] sc;
      logic [W-1:0]  pk;
      logic          ov;
   } exp_t;

   exp_t        sbq[$];
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic        done_prev = 1'b0;

   filter_settle_monitor #(
      .WIDTH(W), .CNT_W(CW), .HOLD_CYCLES(HOLD), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .v_mon(v_mon), .target(target), .tol(tol),
      .busy(busy), .done(done), .settled_ok(settled_ok), .timed_out(timed_out),
      .settle_cycles(settle_cycles), .peak(peak), .overshoot(overshoot)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pop an expectation whenever done is presented.
   always @(negedge clk) begin
      if (rst && done === 1'b1) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 want none (cyc %0d)", cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
            chk("settled_ok", 64'(settled_ok), 64'(e.ok));
            chk("timed_out", 64'(timed_out), 64'(e.to));
            chk("settle_cycles", 64'(settle_cycles), 64'(e.sc));
            chk("peak", 64'(peak), 64'(e.pk));
            chk("overshoot", 64'(overshoot), 64'(e.ov));
            chk("busy_at_done", 64'(busy), 64'd0);
         end
      end
      if (done_prev) chk("done_pulse_width", 64'(done), 64'd0);
      done_prev = done;
   end

   function automatic logic [W-1:0] vfun(input int tid, input int k, input logic [W-1:0] tg);
      case (tid)
         1: return W'(1000);
         2: return (k < 5) ? W'(900) : W'(1010);
         3: return (k == 10) ? W'(1011) : W'(1000);
         4: return W'(0);
         5: return W'(24'hFF_FFFF);
         6: return tg;
         7: return (k < 84) ? W'(0) : W'(1000);
         default: return W'(0);
      endcase
   endfunction

   // One measurement: start, drive samples 0..qk, expect done after sample qk.
   task automatic measure(input int tid, input logic [W-1:0] tg, input logic [W-1:0] tl,
                          input int qk, input logic ok, input logic to, input logic [CW-1:0] sc,
                          input logic [W-1:0] pk, input logic ov, input int stray_k);
      exp_t        e;
      int unsigned s;
      @(posedge clk); #1;
      start = 1'b1; target = tg; tol = tl;
      s = cyc;
      e.done_cyc = s + 2 + qk;
      e.ok = ok; e.to = to; e.sc = sc; e.pk = pk; e.ov = ov;
      sbq.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      for (int k = 0; k <= qk; k++) begin
         v_mon = vfun(tid, k, tg);
         start = (k == stray_k);
         @(posedge clk); #1;
      end
      start = 1'b0;
      for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL done_missing: got no done want done at cyc %0d (test %0d)", e.done_cyc, tid);
         sbq.delete();
      end
      repeat (3) @(posedge clk);
      #1;
      chk("hold_done_low", 64'(done), 64'd0);
      chk("hold_busy", 64'(busy), 64'd0);
      chk("hold_settled_ok", 64'(settled_ok), 64'(ok));
      chk("hold_timed_out", 64'(timed_out), 64'(to));
      chk("hold_settle_cycles", 64'(settle_cycles), 64'(sc));
      chk("hold_peak", 64'(peak), 64'(pk));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_settled_ok", 64'(settled_ok), 64'd0);
      chk("rst_timed_out", 64'(timed_out), 64'd0);
      chk("rst_settle_cycles", 64'(settle_cycles), 64'd0);
      chk("rst_peak", 64'(peak), 64'd0);
      chk("rst_overshoot", 64'(overshoot), 64'd0);
      rst = 1'b1;

      measure(1, W'(1000), W'(10), 15, 1'b1, 1'b0, CW'(0),  W'(1000), 1'b0, -1);
      measure(2, W'(1000), W'(10), 20, 1'b1, 1'b0, CW'(5),  W'(1010), 1'b0, -1);
      measure(3, W'(1000), W'(10), 26, 1'b1, 1'b0, CW'(11), W'(1011), 1'b1, -1);
      measure(4, W'(1000), W'(10), 99, 1'b0, 1'b1, '1,      W'(0),    1'b0, -1);
      measure(5, NEG,      W'(0),  99, 1'b0, 1'b1, '1,      POS >> 0 & W'(24'hFF_FFFF), 1'b1, -1);
      measure(6, NEG,      W'(0),  15, 1'b1, 1'b0, CW'(0),  NEG,      1'b0, -1);
      measure(7, W'(1000), W'(10), 99, 1'b1, 1'b0, CW'(84), W'(1000), 1'b0, -1);
      measure(2, W'(1000), W'(10), 20, 1'b1, 1'b0, CW'(5),  W'(1010), 1'b0, 8);

      // Reset during TRACK at sample 7.
      @(posedge clk); #1;
      start = 1'b1; target = W'(1000); tol = W'(10); v_mon = W'(1000);
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 7; k++) begin
         v_mon = W'(1000);
         @(posedge clk); #1;
      end
      chk("busy_pre_rst", 64'(busy), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_settled_ok", 64'(settled_ok), 64'd0);
      chk("midrst_timed_out", 64'(timed_out), 64'd0);
      chk("midrst_settle_cycles", 64'(settle_cycles), 64'd0);
      chk("midrst_peak", 64'(peak), 64'd0);
      chk("midrst_overshoot", 64'(overshoot), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      chk("post_rst_idle_busy", 64'(busy), 64'd0);
      chk("post_rst_idle_ok", 64'(settled_ok), 64'd0);

      measure(1, W'(1000), W'(10), 15, 1'b1, 1'b0, CW'(0), W'(1000), 1'b0, -1);

      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want test end (cyc %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
